ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among N requesters. Its priority pointer is a one-hot ring register that rotates like a ring counter. A grant is held while the owner keeps requesting, up to a burst limit. On release, priority passes to the next ring position with zero-bubble handoff. It sits between requesting masters and a shared datapath/bus port.

---
 rtl/ring_rr_arbiter_if.sv | 41 ++++
 rtl/ring_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ring_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ring_rr_arbiter_if
//  Purpose  : Request/grant bundle between requesting masters and the
//             ring round-robin arbiter.
//  Signals  : en        - arbitration enable (master -> arbiter)
//             req       - request vector, bit i = requester i
//             gnt       - one-hot grant, zero when idle
//             gnt_valid - |gnt
//             gnt_id    - binary index of the granted requester
//             ptr       - one-hot priority pointer (ring state)
//             burst_cnt - cycles the current grant has been held
//  Modports : master (requester side), slave (arbiter side)
//  Revision : 1.0 - initial release
// ============================================================================
interface ring_rr_arbiter_if #(
  parameter int N         = 4,
  parameter int BURST_MAX = 8
);
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(BURST_MAX + 1);

  logic           en;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ptr;
  logic [CW-1:0]  burst_cnt;

  modport master (
    output en, req,
    input  gnt, gnt_valid, gnt_id, ptr, burst_cnt
  );

  modport slave (
    input  en, req,
    output gnt, gnt_valid, gnt_id, ptr, burst_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ring_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one downstream resource among N
//             requesters. Priority is a one-hot ring pointer; a grant is held
//             while its owner keeps requesting, up to BURST_MAX cycles, and on
//             release priority moves to the ring position after the owner
//             with no idle cycle between consecutive grants.
//  Ports    : clk - clock, rising edge
//             rst - asynchronous active-high reset
//             bus - ring_rr_arbiter_if.slave (en, req in; gnt, gnt_valid,
//                   gnt_id, ptr, burst_cnt out, all registered)
//  Revision : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter #(
  parameter int N         = 4,
  parameter int BURST_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  ring_rr_arbiter_if.slave   bus
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(BURST_MAX + 1);

  localparam logic [N-1:0]   c_ptr_init  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  c_burst_max = CW'(BURST_MAX);
  localparam logic [IDW-1:0] c_last_id   = IDW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic           r_gnt_valid;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [N-1:0]   r_ptr, w_ptr_nxt;
  logic [CW-1:0]  r_burst_cnt, w_burst_cnt_nxt;

  logic [IDW-1:0] w_ptr_id;
  logic [IDW-1:0] w_rot_id;
  logic [IDW-1:0] w_win_cur;
  logic [IDW-1:0] w_win_rot;
  logic           w_any_req;
  logic           w_owner_req;
  logic           w_release;

  // One-hot to binary; relies on the input being one-hot (ptr always is).
  function automatic logic [IDW-1:0] f_oh2bin(input logic [N-1:0] oh);
    logic [IDW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | IDW'(i);
    end
    return b;
  endfunction

  // First requester found searching circularly from 'start' inclusive.
  // The sum start+k never exceeds 2N-2, so IDW+1 bits hold it and a single
  // conditional subtract performs the wrap.
  function automatic logic [IDW-1:0] f_pick(input logic [N-1:0]   r,
                                            input logic [IDW-1:0] start);
    logic [IDW-1:0] sel;
    logic           hit;
    logic [IDW:0]   s;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, start} + (IDW+1)'(k);
      if (s >= (IDW+1)'(N)) s = s - (IDW+1)'(N);
      if (!hit && r[s[IDW-1:0]]) begin
        hit = 1'b1;
        sel = s[IDW-1:0];
      end
    end
    return sel;
  endfunction

  function automatic logic [N-1:0] f_bin2oh(input logic [IDW-1:0] b);
    return c_ptr_init << b;
  endfunction

  assign w_any_req   = |bus.req;
  assign w_owner_req = |(bus.req & r_gnt);
  assign w_ptr_id    = f_oh2bin(r_ptr);
  // Index of the ring slot just after the current owner.
  assign w_rot_id    = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + IDW'(1);
  assign w_win_cur   = f_pick(bus.req, w_ptr_id);
  assign w_win_rot   = f_pick(bus.req, w_rot_id);
  assign w_release   = !w_owner_req || (r_burst_cnt == c_burst_max) || !bus.en;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_ptr_nxt       = r_ptr;
    w_burst_cnt_nxt = r_burst_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.en && w_any_req) begin
          w_gnt_nxt       = f_bin2oh(w_win_cur);
          w_gnt_id_nxt    = w_win_cur;
          w_burst_cnt_nxt = CW'(1);
          w_state_nxt     = S_GRANT;
        end
      end

      S_GRANT: begin
        if (w_release) begin
          // Owner drops to lowest priority; the next winner is picked in the
          // same cycle from the rotated pointer so handoff has no bubble.
          w_ptr_nxt = {r_gnt[N-2:0], r_gnt[N-1]};
          if (bus.en && w_any_req) begin
            w_gnt_nxt       = f_bin2oh(w_win_rot);
            w_gnt_id_nxt    = w_win_rot;
            w_burst_cnt_nxt = CW'(1);
          end else begin
            w_gnt_nxt       = '0;
            w_gnt_id_nxt    = '0;
            w_burst_cnt_nxt = '0;
            w_state_nxt     = S_IDLE;
          end
        end else begin
          w_burst_cnt_nxt = r_burst_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = '0;
        w_gnt_id_nxt    = '0;
        w_burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= c_ptr_init;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_ptr       <= w_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.ptr       = r_ptr;
  assign bus.burst_cnt = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_rr_arbiter
//  Purpose  : Directed self-checking bench for ring_rr_arbiter (N=4,
//             BURST_MAX=8). Inputs change on the falling edge, outputs are
//             sampled on the falling edge after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_rr_arbiter;

  localparam int N  = 4;
  localparam int BM = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ring_rr_arbiter_if #(.N(N), .BURST_MAX(BM)) bus ();

  ring_rr_arbiter #(.N(N), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh2id(input logic [3:0] g);
    logic [31:0] id;
    id = 0;
    for (int i = 0; i < N; i++) if (g[i]) id = i;
    return id;
  endfunction

  // Compare every output against the expected grant, pointer and count.
  task automatic check_state(input string tag, input logic [3:0] g,
                             input logic [3:0] p, input logic [3:0] c);
    check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|g));
    check({tag, ".gnt_id"},    32'(bus.gnt_id),    oh2id(g));
    check({tag, ".ptr"},       32'(bus.ptr),       32'(p));
    check({tag, ".burst_cnt"}, 32'(bus.burst_cnt), 32'(c));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = '0;
    bus.en  = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic [3:0] p;

    // Reset with all requests active: nothing may be granted.
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    #3;
    check_state("t1_rst_async", 4'b0000, 4'b0001, 4'd0);
    cyc(2);
    check_state("t1_rst_held", 4'b0000, 4'b0001, 4'd0);
    bus.req = 4'b0000;
    rst     = 1'b0;

    // Single requester 2 for three cycles, then release.
    bus.req = 4'b0100;
    cyc(1);
    check_state("t2_c1", 4'b0100, 4'b0001, 4'd1);
    cyc(1);
    check_state("t2_c2", 4'b0100, 4'b0001, 4'd2);
    cyc(1);
    check_state("t2_c3", 4'b0100, 4'b0001, 4'd3);
    bus.req = 4'b0000;
    cyc(1);
    check_state("t2_rel", 4'b0000, 4'b1000, 4'd0);
    cyc(1);
    check_state("t2_idle", 4'b0000, 4'b1000, 4'd0);

    // All four requesting: 8-cycle bursts rotating 0,1,2,3,0 with no gaps.
    apply_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 33; c++) begin
      cyc(1);
      g = 4'b0001 << ((c / 8) % 4);
      check_state($sformatf("t3_c%0d", c), g, g, 4'((c % 8) + 1));
    end

    // Requesters 0 and 3 only: alternate, 1 and 2 never granted.
    apply_reset();
    bus.req = 4'b1001;
    for (int c = 0; c < 24; c++) begin
      cyc(1);
      g = ((c / 8) % 2 == 1) ? 4'b1000 : 4'b0001;
      p = ((c / 8) % 2 == 1) ? 4'b0010 : 4'b0001;
      check_state($sformatf("t4_c%0d", c), g, p, 4'((c % 8) + 1));
    end

    // Drop enable while requester 1 owns the grant.
    apply_reset();
    bus.req = 4'b1111;
    cyc(9);
    check_state("t5_owner1", 4'b0010, 4'b0010, 4'd1);
    bus.en = 1'b0;
    cyc(1);
    check_state("t5_en_off1", 4'b0000, 4'b0100, 4'd0);
    cyc(1);
    check_state("t5_en_off2", 4'b0000, 4'b0100, 4'd0);
    bus.en = 1'b1;
    cyc(1);
    check_state("t5_en_on", 4'b0100, 4'b0100, 4'd1);

    // Sole requester 3: expiry re-grants it with the count restarting.
    apply_reset();
    bus.req = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      check_state($sformatf("t6_c%0d", c), 4'b1000, 4'b0001, 4'(c + 1));
    end
    cyc(1);
    check_state("t6_regrant", 4'b1000, 4'b0001, 4'd1);
    cyc(1);
    check_state("t6_regrant2", 4'b1000, 4'b0001, 4'd2);

    // Asynchronous reset between edges drops the grant immediately.
    #2;
    rst = 1'b1;
    #1;
    check_state("t1_rst_midgrant", 4'b0000, 4'b0001, 4'd0);
    cyc(1);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
